// File: rtl/hsci_arb_pkg.sv
// Shared types for the HSCI BRAM arbiter and the modules that reuse its
// per-access tag.
package hsci_arb_pkg;

   typedef enum logic {REQ_HOST = 1'b0, REQ_ENG = 1'b1} req_id_t;

   typedef struct packed {
      logic    vld;
      req_id_t id;
      logic    we;
      logic    err;
   } arb_tag_t;

   localparam int STARVE_CNT_W = 4;

endpackage

// File: rtl/hsci_arb_tag_pipe.sv
// Fixed-depth shift register of access tags with synchronous clear; the tail
// stage lines up with the cycle in which BRAM read data is valid.
module hsci_arb_tag_pipe
   import hsci_arb_pkg::*;
#(
   parameter int unsigned DEPTH = 3
) (
   input  logic     clk_i,
   input  logic     clr_i,
   input  arb_tag_t tag_i,
   output arb_tag_t tag_o
);

   arb_tag_t stage_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (clr_i) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         stage_q[0] <= tag_i;
         for (int unsigned i = 1; i < DEPTH; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/hsci_bram_arbiter.sv
// Two-requester arbiter for the single-port HSCI BRAM: ENG priority with a
// HOST starvation guard, registered BRAM strobes and in-order responses.
module hsci_bram_arbiter
   import hsci_arb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH   = 10,
   parameter int unsigned DEPTH        = 1024,
   parameter int unsigned RD_LATENCY   = 2,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic                  axi_clk,
   input  logic                  axi_reset,
   input  logic                  hreq_valid,
   output logic                  hreq_ready,
   input  logic                  hreq_we,
   input  logic [ADDR_WIDTH-1:0] hreq_addr,
   input  logic [31:0]           hreq_wdata,
   input  logic                  ereq_valid,
   output logic                  ereq_ready,
   input  logic                  ereq_we,
   input  logic [ADDR_WIDTH-1:0] ereq_addr,
   input  logic [31:0]           ereq_wdata,
   output logic                  hrsp_valid,
   output logic [31:0]           hrsp_rdata,
   output logic                  hrsp_err,
   output logic                  ersp_valid,
   output logic [31:0]           ersp_rdata,
   output logic                  ersp_err,
   output logic                  bram_en,
   output logic                  bram_we,
   output logic [ADDR_WIDTH-1:0] bram_addr,
   output logic [31:0]           bram_wdata,
   input  logic [31:0]           bram_rdata
);

   localparam logic [STARVE_CNT_W-1:0] LIMIT   = STARVE_CNT_W'(STARVE_LIMIT);
   localparam logic [ADDR_WIDTH:0]     DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

   logic [STARVE_CNT_W-1:0] starve_cnt_q, starve_cnt_d;
   logic                    both_vld, grant_host, grant_eng, acc;
   req_id_t                 acc_id;
   logic                    acc_we, acc_err;
   logic [ADDR_WIDTH-1:0]   acc_addr;
   logic [31:0]             acc_wdata;
   arb_tag_t                acc_tag, tail_tag;

   logic                    bram_en_q, bram_we_q;
   logic [ADDR_WIDTH-1:0]   bram_addr_q;
   logic [31:0]             bram_wdata_q, rsp_rdata_d;
   logic                    hrsp_valid_q, hrsp_err_q, ersp_valid_q, ersp_err_q;
   logic [31:0]             hrsp_rdata_q, ersp_rdata_q;

   always_comb begin
      both_vld     = hreq_valid & ereq_valid;
      grant_host   = 1'b0;
      grant_eng    = 1'b0;
      starve_cnt_d = starve_cnt_q;
      if (!axi_reset) begin
         if (both_vld) begin
            if (starve_cnt_q == LIMIT) grant_host = 1'b1;
            else                       grant_eng  = 1'b1;
         end else begin
            grant_host = hreq_valid;
            grant_eng  = ereq_valid;
         end
      end
      if (grant_host) begin
         starve_cnt_d = '0;
      end else if (both_vld && grant_eng && starve_cnt_q < LIMIT) begin
         starve_cnt_d = starve_cnt_q + 1'b1;
      end
   end

   assign hreq_ready = grant_host;
   assign ereq_ready = grant_eng;
   assign acc        = grant_host | grant_eng;
   assign acc_id     = grant_eng ? REQ_ENG : REQ_HOST;
   assign acc_we     = grant_eng ? ereq_we    : hreq_we;
   assign acc_addr   = grant_eng ? ereq_addr  : hreq_addr;
   assign acc_wdata  = grant_eng ? ereq_wdata : hreq_wdata;
   assign acc_err    = ({1'b0, acc_addr} >= DEPTH_W);
   assign acc_tag    = '{vld: acc, id: acc_id, we: acc_we, err: acc_err};

   // Tail stage is the tag whose BRAM read data is on bram_rdata this cycle.
   hsci_arb_tag_pipe #(.DEPTH(RD_LATENCY + 1)) u_tag_pipe (
      .clk_i (axi_clk),
      .clr_i (axi_reset),
      .tag_i (acc_tag),
      .tag_o (tail_tag)
   );

   assign rsp_rdata_d = (tail_tag.vld && !tail_tag.we && !tail_tag.err) ? bram_rdata : '0;

   always_ff @(posedge axi_clk) begin
      if (axi_reset) begin
         starve_cnt_q <= '0;
         bram_en_q    <= 1'b0;
         bram_we_q    <= 1'b0;
         bram_addr_q  <= '0;
         bram_wdata_q <= '0;
         hrsp_valid_q <= 1'b0;
         hrsp_rdata_q <= '0;
         hrsp_err_q   <= 1'b0;
         ersp_valid_q <= 1'b0;
         ersp_rdata_q <= '0;
         ersp_err_q   <= 1'b0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
         bram_en_q    <= acc & ~acc_err;
         bram_we_q    <= acc & ~acc_err & acc_we;
         // Out-of-range slots leave the BRAM address/data bus untouched.
         if (acc && !acc_err) begin
            bram_addr_q  <= acc_addr;
            bram_wdata_q <= acc_wdata;
         end
         hrsp_valid_q <= tail_tag.vld && tail_tag.id == REQ_HOST;
         ersp_valid_q <= tail_tag.vld && tail_tag.id == REQ_ENG;
         hrsp_err_q   <= tail_tag.vld && tail_tag.id == REQ_HOST && tail_tag.err;
         ersp_err_q   <= tail_tag.vld && tail_tag.id == REQ_ENG  && tail_tag.err;
         hrsp_rdata_q <= (tail_tag.id == REQ_HOST) ? rsp_rdata_d : '0;
         ersp_rdata_q <= (tail_tag.id == REQ_ENG)  ? rsp_rdata_d : '0;
      end
   end

   assign bram_en    = bram_en_q;
   assign bram_we    = bram_we_q;
   assign bram_addr  = bram_addr_q;
   assign bram_wdata = bram_wdata_q;
   assign hrsp_valid = hrsp_valid_q;
   assign hrsp_rdata = hrsp_rdata_q;
   assign hrsp_err   = hrsp_err_q;
   assign ersp_valid = ersp_valid_q;
   assign ersp_rdata = ersp_rdata_q;
   assign ersp_err   = ersp_err_q;

endmodule

// File: tb/tb_hsci_bram_arbiter.sv
// Bench for hsci_bram_arbiter: directed vectors on a RD_LATENCY=2 instance,
// plus scoreboarded two-requester traffic on RD_LATENCY=1 and 4 instances.
module tb_hsci_bram_arbiter;

   localparam int AW = 11;

   typedef struct {
      logic        eng;
      logic [31:0] data;
      logic        err;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;
   logic [1:0] rnd_done = 2'b00;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [AW-1:0] rnd_addr();
      int unsigned r;
      r = $urandom_range(0, 9);
      if (r < 7) return AW'(r);
      return AW'($urandom_range(1020, 1030));
   endfunction

   // ---------------- directed instance, RD_LATENCY = 2 ----------------
   logic          rst, minit, hv, ev, hwe, ewe, hr, er;
   logic [AW-1:0] haddr, eaddr, baddr;
   logic [31:0]   hwd, ewd, hrd, erd, bwd, brd;
   logic          hrv, erv, herr, eerr, ben, bwe;

   hsci_bram_arbiter #(.ADDR_WIDTH(AW), .DEPTH(1024), .RD_LATENCY(2), .STARVE_LIMIT(4)) u_dut (
      .axi_clk (clk), .axi_reset (rst),
      .hreq_valid (hv), .hreq_ready (hr), .hreq_we (hwe), .hreq_addr (haddr), .hreq_wdata (hwd),
      .ereq_valid (ev), .ereq_ready (er), .ereq_we (ewe), .ereq_addr (eaddr), .ereq_wdata (ewd),
      .hrsp_valid (hrv), .hrsp_rdata (hrd), .hrsp_err (herr),
      .ersp_valid (erv), .ersp_rdata (erd), .ersp_err (eerr),
      .bram_en (ben), .bram_we (bwe), .bram_addr (baddr), .bram_wdata (bwd), .bram_rdata (brd)
   );

   logic [31:0] mem [1024];
   logic [31:0] rpipe [2];
   always @(posedge clk) begin
      if (minit) begin
         for (int i = 0; i < 1024; i++) mem[i] <= 32'hC0DE_0000 + i;
      end else if (ben && bwe) begin
         mem[baddr[9:0]] <= bwd;
      end
      rpipe[0] <= (ben && !bwe) ? mem[baddr[9:0]] : 32'hDEAD_BEEF;
      rpipe[1] <= rpipe[0];
   end
   assign brd = rpipe[1];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; minit = 1'b1;
      hv = 0; ev = 0; hwe = 0; ewe = 0;
      haddr = '0; eaddr = '0; hwd = '0; ewd = '0;
      step(); step();
      hv = 1'b1; #1;
      check("rst_hready", hr, 0);
      check("rst_bram", {ben, bwe, baddr, bwd}, '0);
      check("rst_rsp", {hrv, herr, hrd, erv, eerr, erd}, '0);
      step();
      rst = 1'b0; minit = 1'b0; hv = 1'b0;
      step();

      // write then read back on HOST
      hv = 1; hwe = 1; haddr = 11'h010; hwd = 32'hA5A5_0001; #1;
      check("t1_ready", {hr, er}, 2'b10);
      step();
      check("t1_bram_wr", {ben, bwe}, 2'b11);
      check("t1_baddr", baddr, 11'h010);
      check("t1_bwdata", bwd, 32'hA5A5_0001);
      hwe = 0;
      step();
      check("t1_bram_rd", {ben, bwe}, 2'b10);
      hv = 0;
      step();
      check("t1_quiet3", {hrv, erv}, 2'b00);
      step();
      check("t1_wrsp", {hrv, herr, erv}, 3'b100);
      check("t1_wrsp_data", hrd, 0);
      step();
      check("t1_rrsp", {hrv, herr, erv}, 3'b100);
      check("t1_rdata", hrd, 32'hA5A5_0001);
      step();
      check("t1_quiet6", {hrv, erv}, 2'b00);

      // both requesters hold reads: ENG x4, HOST x1
      hv = 1; ev = 1; haddr = 11'h001; eaddr = 11'h002;
      for (int k = 0; k < 10; k++) begin
         #1;
         check("t2_grant", {hr, er}, (k % 5 == 4) ? 2'b10 : 2'b01);
         step();
      end
      hv = 0; ev = 0;
      repeat (8) step();

      // in-range then out-of-range ENG reads
      ev = 1; eaddr = 11'h3FF;
      step();
      check("t3_ben_in", {ben, bwe, baddr}, {2'b10, 11'h3FF});
      eaddr = 11'h400;
      step();
      check("t3_ben_err", {ben, bwe, baddr}, {2'b00, 11'h3FF});
      ev = 0;
      step(); step();
      check("t3_rsp_in", {erv, eerr, hrv}, 3'b100);
      check("t3_rdata_in", erd, 32'hC0DE_03FF);
      step();
      check("t3_rsp_err", {erv, eerr, hrv}, 3'b110);
      check("t3_rdata_err", erd, 0);

      // ENG write then HOST read of the same word
      step();
      ev = 1; ewe = 1; eaddr = 11'h020; ewd = 32'h1234_5678; #1;
      check("t4_eready", {hr, er}, 2'b01);
      step();
      ev = 0; ewe = 0; hv = 1; hwe = 0; haddr = 11'h020; #1;
      check("t4_hready", {hr, er}, 2'b10);
      step();
      hv = 0;
      step(); step();
      check("t4_ersp", {erv, eerr, hrv, erd}, {3'b100, 32'h0});
      step();
      check("t4_hrsp", {hrv, herr, erv}, 3'b100);
      check("t4_raw_data", hrd, 32'h1234_5678);

      // three reads in flight, then a one-cycle reset
      step();
      hv = 1; hwe = 0; haddr = 11'h030;
      step(); haddr = 11'h031;
      step(); haddr = 11'h032;
      step(); rst = 1; #1;
      check("t5_ready_in_rst", hr, 0);
      step();
      rst = 0;
      check("t5_bram_rst", {ben, bwe, baddr, bwd}, '0);
      check("t5_rsp_rst", {hrv, herr, hrd, erv, eerr, erd}, '0);
      haddr = 11'h033; #1;
      check("t5_new_ready", hr, 1);
      step();
      hv = 0;
      check("t5_new_ben", {ben, baddr}, {1'b1, 11'h033});
      for (int k = 0; k < 3; k++) begin
         check("t5_no_stale", {hrv, erv}, 2'b00);
         step();
      end
      check("t5_new_rsp", {hrv, herr, erv}, 3'b100);
      check("t5_new_rdata", hrd, 32'hC0DE_0033);

      for (int k = 0; k < 3000 && rnd_done != 2'b11; k++) @(negedge clk);
      check("rnd_finished", rnd_done, 2'b11);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // ---------------- scoreboarded traffic, RD_LATENCY = 1 and 4 ----------------
   for (genvar g = 0; g < 2; g++) begin : g_rnd
      localparam int RL = (g == 0) ? 1 : 4;

      logic          r_rst, r_minit, r_hv, r_ev, r_hwe, r_ewe, r_hr, r_er;
      logic [AW-1:0] r_haddr, r_eaddr, r_baddr;
      logic [31:0]   r_hwd, r_ewd, r_hrd, r_erd, r_bwd, r_brd;
      logic          r_hrv, r_erv, r_herr, r_eerr, r_ben, r_bwe;
      logic [31:0]   r_mem [1024];
      logic [31:0]   r_rp [RL];
      logic [31:0]   shadow [1024];
      exp_t          sb [$];

      hsci_bram_arbiter #(.ADDR_WIDTH(AW), .DEPTH(1024), .RD_LATENCY(RL), .STARVE_LIMIT(2)) u_dut (
         .axi_clk (clk), .axi_reset (r_rst),
         .hreq_valid (r_hv), .hreq_ready (r_hr), .hreq_we (r_hwe), .hreq_addr (r_haddr), .hreq_wdata (r_hwd),
         .ereq_valid (r_ev), .ereq_ready (r_er), .ereq_we (r_ewe), .ereq_addr (r_eaddr), .ereq_wdata (r_ewd),
         .hrsp_valid (r_hrv), .hrsp_rdata (r_hrd), .hrsp_err (r_herr),
         .ersp_valid (r_erv), .ersp_rdata (r_erd), .ersp_err (r_eerr),
         .bram_en (r_ben), .bram_we (r_bwe), .bram_addr (r_baddr), .bram_wdata (r_bwd), .bram_rdata (r_brd)
      );

      always @(posedge clk) begin
         if (r_minit) begin
            for (int i = 0; i < 1024; i++) r_mem[i] <= 32'h5000_0000 + i;
         end else if (r_ben && r_bwe) begin
            r_mem[r_baddr[9:0]] <= r_bwd;
         end
         r_rp[0] <= (r_ben && !r_bwe) ? r_mem[r_baddr[9:0]] : 32'hDEAD_BEEF;
         for (int i = 1; i < RL; i++) r_rp[i] <= r_rp[i-1];
      end
      assign r_brd = r_rp[RL-1];

      initial begin : drv
         logic hacc, eacc, a_err;
         exp_t e;
         hacc = 0; eacc = 0;
         r_rst = 1; r_minit = 1; r_hv = 0; r_ev = 0; r_hwe = 0; r_ewe = 0;
         r_haddr = '0; r_eaddr = '0; r_hwd = '0; r_ewd = '0;
         for (int i = 0; i < 1024; i++) shadow[i] = 32'h5000_0000 + i;
         repeat (3) @(negedge clk);
         r_rst = 0; r_minit = 0;
         for (int n = 0; n < 420; n++) begin
            @(negedge clk);
            if (r_hrv || r_erv) begin
               if (sb.size() == 0) begin
                  check("rnd_spurious", {r_hrv, r_erv}, 2'b00);
               end else begin
                  e = sb.pop_front();
                  check("rnd_port", {r_hrv, r_erv}, e.eng ? 2'b01 : 2'b10);
                  check("rnd_rdata", e.eng ? r_erd : r_hrd, e.data);
                  check("rnd_err", e.eng ? r_eerr : r_herr, e.err);
                  check("rnd_latency", cyc - e.cyc, RL + 2);
               end
            end
            if (hacc) r_hv = 0;
            if (eacc) r_ev = 0;
            if (n < 400 && !r_hv && $urandom_range(0, 3) != 0) begin
               r_hv = 1; r_hwe = ($urandom_range(0, 2) == 0); r_haddr = rnd_addr(); r_hwd = $urandom;
            end
            if (n < 400 && !r_ev && $urandom_range(0, 3) != 0) begin
               r_ev = 1; r_ewe = ($urandom_range(0, 2) == 0); r_eaddr = rnd_addr(); r_ewd = $urandom;
            end
            #1;
            hacc = r_hv && r_hr;
            eacc = r_ev && r_er;
            check("rnd_onehot", hacc & eacc, 0);
            if (hacc || eacc) begin
               e.eng = eacc;
               e.cyc = cyc;
               a_err = (eacc ? r_eaddr : r_haddr) >= AW'(1024);
               e.err = a_err;
               if (a_err || (eacc ? r_ewe : r_hwe)) e.data = '0;
               else e.data = shadow[(eacc ? r_eaddr : r_haddr) % 1024];
               if (!a_err && (eacc ? r_ewe : r_hwe))
                  shadow[(eacc ? r_eaddr : r_haddr) % 1024] = eacc ? r_ewd : r_hwd;
               sb.push_back(e);
            end
         end
         check("rnd_drained", sb.size(), 0);
         rnd_done[g] = 1'b1;
      end
   end

endmodule

// File: doc/hsci_bram_arbiter.md
# hsci_bram_arbiter

Shares the single-port HSCI command/data BRAM between two requesters: the host-side AXI-lite register slave (requester 0, HOST) and the HSCI link engine (requester 1, ENG). It sits between those two blocks and the BRAM. It grants at most one access per cycle with ENG priority and a bounded starvation guard for HOST. It pipelines the BRAM read latency and returns an in-order response to whichever requester issued each access.

## Interface
Parameters:
- ADDR_WIDTH, 10: BRAM word-address width.
- DEPTH, 1024: number of valid BRAM words; legal addresses are 0..DEPTH-1.
- RD_LATENCY, 2: BRAM cycles from bram_en to valid bram_rdata; legal range 1..4.
- STARVE_LIMIT, 4: consecutive contested ENG grants after which HOST is forced a grant; legal range 1..15.

Ports:
- axi_clk  in  1  sole clock.
- axi_reset  in  1  synchronous, active-high reset.
- hreq_valid / ereq_valid  in  1  request valid (HOST / ENG).
- hreq_ready / ereq_ready  out  1  request accepted this cycle.
- hreq_we / ereq_we  in  1  1 = write, 0 = read.
- hreq_addr / ereq_addr  in  ADDR_WIDTH  word address.
- hreq_wdata / ereq_wdata  in  32  write data.
- hrsp_valid / ersp_valid  out  1  one-cycle response strobe; no backpressure.
- hrsp_rdata / ersp_rdata  out  32  read data; 0 for writes and errors.
- hrsp_err / ersp_err  out  1  address out of range.
- bram_en  out  1  BRAM access strobe.
- bram_we  out  1  BRAM write enable.
- bram_addr  out  ADDR_WIDTH  BRAM address.
- bram_wdata  out  32  BRAM write data.
- bram_rdata  in  32  BRAM read data.

## Operation
- Arbitration is combinational on the current valids.
  - Only one valid: that requester is granted.
  - Both valid: ENG wins, unless starve_cnt == STARVE_LIMIT, in which case HOST wins.
- The ready of the granted requester is 1 and the other ready is 0. An accepted request is valid & ready.
- starve_cnt (4 bit) behaviour:
  - Increments on each cycle where both are valid and ENG is granted.
  - Clears on any HOST grant.
  - Holds otherwise.
  - Never exceeds STARVE_LIMIT.
- Address check: addr >= DEPTH is an error.
  - The request is still accepted and still occupies its pipeline slot.
  - bram_en stays 0 for that slot.
  - Response carries err = 1 and rdata = 0.
- Every accepted request, read or write, produces exactly one response on its own requester's port.
  - Responses come back in acceptance order.
  - Write responses carry rdata = 0 and err = 0 for in-range addresses.
- A tag pipeline of depth RD_LATENCY+1 tracks {valid, id, we, err} per slot. This is independent of BRAM contents.

## Timing
- Request accepted in cycle T:
  - bram_en / bram_we / bram_addr / bram_wdata are registered and asserted in T+1, for one cycle.
  - bram_rdata is sampled in T+1+RD_LATENCY.
  - The response strobe is registered and asserted in T+2+RD_LATENCY. With defaults this is T+4.
- Throughput is one access per cycle sustained, with no bubbles between back-to-back grants, including HOST/ENG alternation.
- Read-after-write to the same address on consecutive accepted cycles returns the new data. Writes reach the BRAM first in order.
- Simultaneous valid from both requesters: exactly one is accepted. The loser must hold its request stable until its ready is 1.
- Reset values: all readies 0, bram_en 0, bram_we 0, bram_addr 0, bram_wdata 0, all rsp_valid 0, all rsp_rdata 0, all rsp_err 0, starve_cnt 0, tag pipeline cleared.
  - Readies are forced 0 while axi_reset is high.
- Reset mid-operation: in-flight accesses are discarded with no responses. The cycle after reset deasserts accepts new requests normally.
- The bram_* outputs hold their last address and data when bram_en is 0. Only bram_en and bram_we return to 0.

## Structure
- Shared package hsci_arb_pkg holds:
  - typedef enum logic {REQ_HOST = 1'b0, REQ_ENG = 1'b1} req_id_t.
  - typedef struct packed {logic vld; req_id_t id; logic we; logic err;} arb_tag_t.
  - localparam STARVE_CNT_W = 4.
- One sub-module, hsci_arb_tag_pipe: a parameterised arb_tag_t shift register of depth RD_LATENCY+1 with synchronous clear. It is also reused by the upcoming engine-side FIFO.
- The top level contains the grant logic, starve counter, BRAM output registers and response demux.

## Test plan
- HOST writes 0xA5A5_0001 to addr 0x010, then reads it back -> one bram_we pulse at T+1; read hrsp_valid at T+4 with rdata 0xA5A5_0001 and err 0; ersp_valid never pulses.
- HOST and ENG both hold read valids continuously (STARVE_LIMIT = 4) -> grant sequence ENG ×4, HOST ×1, repeating; starve_cnt peaks at 4; no cycle has both readies high.
- ENG read addr 0x3FF, then addr 0x400 (DEPTH = 1024) -> first response has err 0 with BRAM data; second has err 1, rdata 0, and no bram_en for that slot; responses arrive on consecutive cycles.
- Back-to-back ENG write 0x1234_5678 to 0x020 then HOST read of 0x020 -> hrsp_rdata 0x1234_5678 one cycle after ersp_valid.
- Three reads accepted, then axi_reset asserted for 1 cycle at T+2 -> no rsp_valid afterwards for those reads; all outputs at reset values; a new read issued after reset completes at acceptance + 4.
- RD_LATENCY = 1 and RD_LATENCY = 4 builds -> response at T+3 and T+6 respectively, with order and data preserved under random two-requester traffic checked by a scoreboard.
